// File: rtl/crossy_pkg.sv
// Shared types and constants for the road/frog game blocks.
//   lane_state_t : spawn FSM states of a car lane
//   LFSR_W       : width of the pseudo-random generators
//   LFSR_TAPS    : Galois tap mask for x^8+x^6+x^5+x^4+1
//   lfsr_next()  : one Galois step of that polynomial
package crossy_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic {
    READY = 1'b0,
    GAP   = 1'b1
  } lane_state_t;

  // Right-shifting Galois form: the bit shifted out feeds back through the
  // tap mask. A nonzero state never maps to zero.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    lfsr_next = (q >> 1) ^ (q[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Galois LFSR, advances once per cycle when adv is high.
//   clk   : system clock
//   reset : synchronous, active-high; loads seed
//   adv   : advance one step this cycle
//   seed  : reset value (must be nonzero)
//   q     : current LFSR state
module lfsr8
  import crossy_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              adv,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (adv) q_d = lfsr_next(q_q);
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= seed;
    else       q_q <= q_d;
  end

  assign q = q_q;

  always @(posedge clk) begin
    if (!reset) assert (q_q != '0) else $error("lfsr8: state reached zero");
  end

endmodule

// File: rtl/car_lane.sv
// One road lane of cars. On each movement step (enable & run) the car pattern
// shifts one cell toward the exit and a new car may enter, chosen by an LFSR
// and throttled so consecutive spawns keep at least MIN_GAP empty cells.
//   clk          : system clock
//   reset        : synchronous, active-high
//   enable       : single-cycle movement tick
//   run          : game active; 0 freezes the lane
//   frog_present : frog is in this row
//   frog_col     : frog column
//   lane         : car occupancy, 1 = car
//   hit          : registered frog/car collision flag (1-cycle latency)
//   cars_passed  : saturating count of cars that left the lane
module car_lane
  import crossy_pkg::*;
#(
  parameter int          WIDTH        = 16,
  parameter int          DIR          = 0,
  parameter int          MIN_GAP      = 2,
  parameter logic [7:0]  SEED         = 8'hA5,
  parameter logic [8:0]  SPAWN_THRESH = 9'd64,
  localparam int         COL_W        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             run,
  input  logic             frog_present,
  input  logic [COL_W-1:0] frog_col,
  output logic [WIDTH-1:0] lane,
  output logic             hit,
  output logic [7:0]       cars_passed
);

  localparam logic [3:0] GAP_LAST = (MIN_GAP == 0) ? 4'd0 : 4'(MIN_GAP - 1);

  logic             step;
  logic [LFSR_W-1:0] lfsr;
  logic             spawn;
  logic             exit_bit;
  logic             col_ok;

  lane_state_t      state_q, state_d;
  logic [3:0]       gap_q, gap_d;
  logic [WIDTH-1:0] lane_q, lane_d;
  logic             hit_q, hit_d;
  logic [7:0]       passed_q, passed_d;

  assign step = enable & run;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .adv   (step),
    .seed  (SEED),
    .q     (lfsr)
  );

  assign spawn    = (state_q == READY) && ({1'b0, lfsr} < SPAWN_THRESH);
  assign exit_bit = (DIR == 0) ? lane_q[WIDTH-1] : lane_q[0];

  // With a power-of-two width every encodable column is on the lane.
  if ((1 << COL_W) == WIDTH) begin : g_col_full
    assign col_ok = 1'b1;
  end else begin : g_col_part
    assign col_ok = (32'(frog_col) < WIDTH);
  end

  // Hit looks at the pre-step lane every cycle, stepping or not.
  always_comb begin
    hit_d = frog_present && col_ok && lane_q[frog_col];
  end

  always_comb begin
    lane_d   = lane_q;
    passed_d = passed_q;
    if (step) begin
      if (DIR == 0) lane_d = {lane_q[WIDTH-2:0], spawn};
      else          lane_d = {spawn, lane_q[WIDTH-1:1]};
      if (exit_bit && passed_q != 8'hFF) passed_d = passed_q + 8'd1;
    end
  end

  // Spawn FSM: after a spawn, GAP burns MIN_GAP steps before READY returns.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    if (step) begin
      case (state_q)
        READY: begin
          if (spawn && MIN_GAP != 0) begin
            state_d = GAP;
            gap_d   = 4'd0;
          end
        end
        GAP: begin
          gap_d = gap_q + 4'd1;
          if (gap_q == GAP_LAST) state_d = READY;
        end
        default: state_d = READY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= READY;
      gap_q    <= 4'd0;
      lane_q   <= '0;
      hit_q    <= 1'b0;
      passed_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      lane_q   <= lane_d;
      hit_q    <= hit_d;
      passed_q <= passed_d;
    end
  end

  assign lane        = lane_q;
  assign hit         = hit_q;
  assign cars_passed = passed_q;

  // Spawn history over the last MIN_GAP steps: a spawn must never land while
  // any of them still holds a car.
  if (MIN_GAP > 0) begin : g_gap_chk
    logic [MIN_GAP-1:0] hist_q, hist_d;

    always_comb begin
      hist_d = hist_q;
      if (step) hist_d = (hist_q << 1) | MIN_GAP'(spawn);
    end

    always_ff @(posedge clk) begin
      if (reset) hist_q <= '0;
      else       hist_q <= hist_d;
    end

    always @(posedge clk) begin
      if (!reset && step && spawn)
        assert (hist_q == '0) else $error("car_lane: spawn inside minimum gap");
    end
  end

endmodule

// File: tb/tb_car_lane.sv
module tb_car_lane;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable, run, fp;
  logic [3:0] fcol;

  logic [7:0]       lane0, lane1, lane2;
  logic [15:0]      lane3;
  logic [11:0]      lane4;
  logic [4:0]       hit;
  logic [4:0][7:0]  cp;

  car_lane #(.WIDTH(8), .DIR(0), .MIN_GAP(2), .SEED(8'hA5), .SPAWN_THRESH(9'd256)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .run(run), .frog_present(fp),
    .frog_col(fcol[2:0]), .lane(lane0), .hit(hit[0]), .cars_passed(cp[0]));
  car_lane #(.WIDTH(8), .DIR(1), .MIN_GAP(2), .SEED(8'hA5), .SPAWN_THRESH(9'd256)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .run(run), .frog_present(fp),
    .frog_col(fcol[2:0]), .lane(lane1), .hit(hit[1]), .cars_passed(cp[1]));
  car_lane #(.WIDTH(8), .DIR(0), .MIN_GAP(2), .SEED(8'hA5), .SPAWN_THRESH(9'd0)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .run(run), .frog_present(fp),
    .frog_col(fcol[2:0]), .lane(lane2), .hit(hit[2]), .cars_passed(cp[2]));
  car_lane #(.WIDTH(16), .DIR(0), .MIN_GAP(2), .SEED(8'hA5), .SPAWN_THRESH(9'd64)) u3 (
    .clk(clk), .reset(reset), .enable(enable), .run(run), .frog_present(fp),
    .frog_col(fcol), .lane(lane3), .hit(hit[3]), .cars_passed(cp[3]));
  car_lane #(.WIDTH(12), .DIR(1), .MIN_GAP(0), .SEED(8'h01), .SPAWN_THRESH(9'd128)) u4 (
    .clk(clk), .reset(reset), .enable(enable), .run(run), .frog_present(fp),
    .frog_col(fcol), .lane(lane4), .hit(hit[4]), .cars_passed(cp[4]));

  // Reference model configuration, one entry per instance above.
  int         mw[5] = '{8, 8, 8, 16, 12};
  int         md[5] = '{0, 1, 0, 0, 1};
  int         mg[5] = '{2, 2, 2, 2, 0};
  int         mt[5] = '{256, 256, 0, 64, 128};
  logic [7:0] ms[5] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01};

  // Model state: lane bits, lfsr, steps since last spawn, exits, hit.
  logic [15:0] m_lane[5];
  logic [7:0]  m_lfsr[5];
  int          m_since[5];
  int          m_pass[5];
  bit          m_hit[5];

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] get_lane(input int i);
    case (i)
      0:       get_lane = {8'h0, lane0};
      1:       get_lane = {8'h0, lane1};
      2:       get_lane = {8'h0, lane2};
      3:       get_lane = lane3;
      default: get_lane = {4'h0, lane4};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_lane[i]  = '0;
      m_lfsr[i]  = ms[i];
      m_since[i] = 1000;
      m_pass[i]  = 0;
      m_hit[i]   = 1'b0;
    end
  endtask

  // Spawn allowed once at least MIN_GAP non-spawning steps followed the last one.
  task automatic model_cycle();
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 5; i++) begin
      int          col;
      bit          nh, sp, ex;
      logic [15:0] mask;
      col  = (mw[i] == 8) ? int'(fcol[2:0]) : int'(fcol);
      nh   = fp && (col < mw[i]) && m_lane[i][col];
      mask = 16'((32'd1 << mw[i]) - 1);
      if (enable && run) begin
        sp = (m_since[i] >= mg[i]) && (int'(m_lfsr[i]) < mt[i]);
        ex = (md[i] == 0) ? m_lane[i][mw[i]-1] : m_lane[i][0];
        if (md[i] == 0) m_lane[i] = ((m_lane[i] << 1) | 16'(sp)) & mask;
        else            m_lane[i] = (m_lane[i] >> 1) | (16'(sp) << (mw[i] - 1));
        if (ex && m_pass[i] < 255) m_pass[i]++;
        m_lfsr[i]  = (m_lfsr[i] >> 1) ^ (m_lfsr[i][0] ? 8'hB8 : 8'h00);
        m_since[i] = sp ? 0 : ((m_since[i] < 1000) ? m_since[i] + 1 : 1000);
      end
      m_hit[i] = nh;
    end
  endtask

  task automatic tick(input bit r, input bit e, input bit rn, input bit f, input logic [3:0] c);
    reset = r; enable = e; run = rn; fp = f; fcol = c;
    model_cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("m_lane%0d", i), 32'(get_lane(i)), 32'(m_lane[i]));
      chk($sformatf("m_hit%0d", i), 32'(hit[i]), 32'(m_hit[i]));
      chk($sformatf("m_passed%0d", i), 32'(cp[i]), 32'(m_pass[i]));
    end
  endtask

  logic [7:0] t0[6] = '{8'h01, 8'h02, 8'h04, 8'h09, 8'h12, 8'h24};
  logic [7:0] t1[4] = '{8'h80, 8'h40, 8'h20, 8'h90};

  initial begin
    reset = 1'b1; enable = 1'b0; run = 1'b1; fp = 1'b0; fcol = 4'd0;
    model_reset();
    tick(1, 0, 1, 0, 0);
    tick(1, 0, 1, 0, 0);
    chk("rst_lane", 32'(lane0), 32'h0);
    chk("rst_hit", 32'(hit[0]), 32'h0);
    chk("rst_passed", 32'(cp[0]), 32'h0);

    for (int s = 1; s <= 16; s++) begin
      tick(0, 1, 1, 0, 0);
      if (s <= 6) chk($sformatf("dir0_step%0d", s), 32'(lane0), 32'(t0[s-1]));
      if (s <= 4) chk($sformatf("dir1_step%0d", s), 32'(lane1), 32'(t1[s-1]));
      if (s == 1) begin
        tick(0, 0, 1, 1, 4'd0);
        chk("hit_col0", 32'(hit[0]), 32'h1);
        tick(0, 0, 1, 1, 4'd1);
        chk("hit_col1", 32'(hit[0]), 32'h0);
        tick(0, 0, 1, 0, 4'd0);
        chk("hit_nofrog", 32'(hit[0]), 32'h0);
      end else begin
        repeat (3) tick(0, 0, 1, 0, 0);
      end
    end
    chk("passed16", 32'(cp[0]), 32'd3);
    chk("lane16", 32'(lane0), 32'h49);
    chk("thresh0_lane", 32'(lane2), 32'h0);

    for (int k = 0; k < 10; k++) begin
      tick(0, 1, 0, 0, 0);
      tick(0, 0, 0, 0, 0);
    end
    chk("frozen_lane", 32'(lane0), 32'h49);
    chk("frozen_passed", 32'(cp[0]), 32'd3);

    tick(1, 1, 1, 1, 4'd0);
    chk("rst_en_lane", 32'(lane0), 32'h0);
    chk("rst_en_passed", 32'(cp[0]), 32'h0);
    chk("rst_en_hit", 32'(hit[0]), 32'h0);
    tick(0, 1, 1, 0, 0);
    chk("post_rst_step", 32'(lane0), 32'h01);

    for (int k = 0; k < 3000; k++) begin
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
